// File: rtl/serial_addsub_unit_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master drives the start request and operands; the slave returns status and result.
interface serial_addsub_unit_if #(
    parameter int WIDTH = 8
);
    logic             st;
    logic             mode;
    logic             acc_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             n;
    logic             v;
    logic             c;

    modport master (
        output st, mode, acc_en, a, b,
        input  busy, done, result, z, n, v, c
    );

    modport slave (
        input  st, mode, acc_en, a, b,
        output busy, done, result, z, n, v, c
    );
endinterface

// File: rtl/serial_addsub_unit.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with a
// start/busy/done handshake, accumulate mode and registered Z/N/V/C flags.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc_sr;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             cb;
    logic             mode_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q;
    logic             n_q;
    logic             v_q;
    logic             c_q;

    logic             bit_a;
    logic             bit_b;
    logic             sum_bit;
    logic             cb_next;
    logic             last;
    logic [WIDTH-1:0] assembled;

    assign bit_a     = a_sr[0];
    assign bit_b     = b_sr[0];
    assign sum_bit   = bit_a ^ bit_b ^ cb;
    assign cb_next   = mode_q ? ((bit_a & bit_b) | (bit_a & cb) | (bit_b & cb))
                              : ((~bit_a & bit_b) | (~bit_a & cb) | (bit_b & cb));
    assign last      = (cnt == LAST);
    assign assembled = {sum_bit, acc_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.st) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            SHIFT:   bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Accumulate mode feeds the last completed result back in as operand A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sr <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            cb     <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.st) begin
                        a_sr   <= bus.acc_en ? result_q : bus.a;
                        b_sr   <= bus.b;
                        mode_q <= bus.mode;
                        cb     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    acc_sr <= assembled;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    cb     <= cb_next;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // On the final shift the operand LSBs hold the original operand MSBs,
    // which is exactly what the overflow rule needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
        end else if (state == SHIFT && last) begin
            result_q <= assembled;
            z_q      <= (assembled == '0);
            n_q      <= sum_bit;
            c_q      <= cb_next;
            v_q      <= mode_q ? ((bit_a == bit_b) && (sum_bit != bit_a))
                               : ((bit_a != bit_b) && (sum_bit != bit_a));
        end
    end

    assign bus.result = result_q;
    assign bus.z      = z_q;
    assign bus.n      = n_q;
    assign bus.v      = v_q;
    assign bus.c      = c_q;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: table-driven operations with a
// scoreboard queue, plus hand-written handshake, reset and WIDTH=16 sequences.
module tb_serial_addsub_unit;
    typedef struct {
        logic [15:0] result;
        bit          z;
        bit          n;
        bit          v;
        bit          c;
    } exp_t;

    typedef struct {
        bit         mode;
        bit         acc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        bit         z;
        bit         n;
        bit         v;
        bit         c;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    exp_t       q8[$];
    exp_t       mon_e;
    logic       done_prev = 1'b0;
    logic [7:0] res_prev = 8'h00;
    logic [7:0] prev8 = 8'h00;

    serial_addsub_unit_if #(.WIDTH(8))  bus8 ();
    serial_addsub_unit_if #(.WIDTH(16)) bus16 ();

    serial_addsub_unit #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_addsub_unit #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input bit mode,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] s;
        logic [31:0] r;
        logic        am;
        logic        bm;
        logic        rm;
        exp_t        e;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        a = a_in & mask;
        b = b_in & mask;
        s = mode ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
        r = s[31:0] & mask;
        am = a[w-1];
        bm = b[w-1];
        rm = r[w-1];
        e.result = r[15:0];
        e.c = mode ? s[w] : (a < b);
        e.v = mode ? ((am == bm) && (rm != am)) : ((am != bm) && (rm != am));
        e.z = (r == 32'h0);
        e.n = rm;
        return e;
    endfunction

    // Scoreboard side: every Done pops one expectation; Result must hold otherwise.
    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_done: got Done=1, expected no pending operation");
            end else begin
                mon_e = q8.pop_front();
                check("result", {24'h0, bus8.result}, {16'h0, mon_e.result});
                check("flag_z", {31'h0, bus8.z}, {31'h0, mon_e.z});
                check("flag_n", {31'h0, bus8.n}, {31'h0, mon_e.n});
                check("flag_v", {31'h0, bus8.v}, {31'h0, mon_e.v});
                check("flag_c", {31'h0, bus8.c}, {31'h0, mon_e.c});
            end
            check("done_one_cycle", {31'h0, done_prev}, 32'h0);
        end else if (rst === 1'b0) begin
            check("result_hold", {24'h0, bus8.result}, {24'h0, res_prev});
        end
        done_prev = bus8.done;
        res_prev  = bus8.result;
    end

    task automatic wait_idle8();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((bus8.busy || bus8.done) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic apply_stimulus(input bit mode, input bit acc, input logic [7:0] a,
                                  input logic [7:0] b, input exp_t e, input bit scramble,
                                  input string tag);
        int n;
        int nb;
        wait_idle8();
        bus8.st     = 1'b1;
        bus8.mode   = mode;
        bus8.acc_en = acc;
        bus8.a      = a;
        bus8.b      = b;
        q8.push_back(e);
        @(posedge clk);
        #1 bus8.st = 1'b0;
        n  = 0;
        nb = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus8.busy) nb++;
            if (bus8.done) break;
            if (scramble) begin
                bus8.a      = 8'($urandom);
                bus8.b      = 8'($urandom);
                bus8.mode   = 1'($urandom);
                bus8.acc_en = 1'($urandom);
                bus8.st     = 1'b0;
            end
        end
        check({tag, "_done_latency"}, n, 9);
        check({tag, "_busy_cycles"}, nb, 8);
    endtask

    vec_t vecs[11];

    initial begin
        exp_t e;
        int   ndone;
        int   tdone[3];
        int   n;
        int   nb;

        vecs[0]  = '{1'b0, 1'b0, 8'h34, 8'hF7, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'h12, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 8'h40, 8'h23, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'hAA, 8'h00, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h33, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'hC0, 8'hC0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};

        bus8.st = 1'b0;  bus8.mode = 1'b0;  bus8.acc_en = 1'b0;  bus8.a = 8'h0;  bus8.b = 8'h0;
        bus16.st = 1'b0; bus16.mode = 1'b0; bus16.acc_en = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0;

        repeat (3) @(negedge clk);
        check("reset_busy",   {31'h0, bus8.busy}, 32'h0);
        check("reset_done",   {31'h0, bus8.done}, 32'h0);
        check("reset_result", {24'h0, bus8.result}, 32'h0);
        check("reset_flags",  {28'h0, bus8.z, bus8.n, bus8.v, bus8.c}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            e.result = {8'h00, vecs[i].r};
            e.z = vecs[i].z;
            e.n = vecs[i].n;
            e.v = vecs[i].v;
            e.c = vecs[i].c;
            apply_stimulus(vecs[i].mode, vecs[i].acc, vecs[i].a, vecs[i].b, e, 1'b0,
                           $sformatf("vec%0d", i));
            prev8 = vecs[i].r;
        end

        // Operands and controls churn throughout SHIFT; only the sampled values count.
        e = model(8, 1'b0, 32'hA5, 32'h3C);
        apply_stimulus(1'b0, 1'b0, 8'hA5, 8'h3C, e, 1'b1, "scramble");
        prev8 = e.result[7:0];

        wait_idle8();
        bus8.st = 1'b1; bus8.mode = 1'b1; bus8.acc_en = 1'b0; bus8.a = 8'h21; bus8.b = 8'h10;
        e = model(8, 1'b1, 32'h21, 32'h10);
        for (int i = 0; i < 3; i++) q8.push_back(e);
        ndone = 0;
        n = 0;
        while (ndone < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus8.done) begin
                tdone[ndone] = cyc;
                ndone++;
            end
        end
        bus8.st = 1'b0;
        check("hold_done_count", ndone, 3);
        if (ndone == 3) begin
            check("hold_period_1", tdone[1] - tdone[0], 10);
            check("hold_period_2", tdone[2] - tdone[1], 10);
        end
        repeat (12) @(negedge clk);
        check("hold_queue_drained", q8.size(), 0);
        prev8 = e.result[7:0];

        wait_idle8();
        bus8.st = 1'b1; bus8.mode = 1'b1; bus8.acc_en = 1'b0; bus8.a = 8'h99; bus8.b = 8'h11;
        @(posedge clk);
        #1 bus8.st = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy",   {31'h0, bus8.busy}, 32'h0);
        check("abort_done",   {31'h0, bus8.done}, 32'h0);
        check("abort_result", {24'h0, bus8.result}, 32'h0);
        check("abort_flags",  {28'h0, bus8.z, bus8.n, bus8.v, bus8.c}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done_queue", q8.size(), 0);
        prev8 = 8'h00;
        e = model(8, 1'b0, 32'h0A, 32'h03);
        apply_stimulus(1'b0, 1'b0, 8'h0A, 8'h03, e, 1'b0, "post_reset");
        repeat (3) @(negedge clk);
        check("post_reset_queue_drained", q8.size(), 0);

        @(negedge clk);
        bus16.st = 1'b1; bus16.mode = 1'b0; bus16.a = 16'h8000; bus16.b = 16'h0001;
        @(posedge clk);
        #1 bus16.st = 1'b0;
        n  = 0;
        nb = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus16.busy) nb++;
            if (bus16.done) break;
        end
        check("w16_done_latency", n, 17);
        check("w16_busy_cycles", nb, 16);
        check("w16_result", {16'h0, bus16.result}, 32'h7FFF);
        check("w16_flags_znvc", {28'h0, bus16.z, bus16.n, bus16.v, bus16.c}, 32'h2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Parametrised bit-serial adder/subtractor. Successor to the 8-bit serial subtractor datapath: accumulator and operand shift registers, a carry/borrow flip-flop, a full adder/subtractor cell and a status register.
- Generalises operand width and adds an add/subtract mode, a start/busy/done handshake, and accumulate (chained) operation.
- Flags Z/N/V/C are computed from the serial result and registered at completion.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- R  input  1  reset; asynchronous, active-high.
- St  input  1  start request; sampled only in IDLE.
- Mode  input  1  0 = subtract (A - B), 1 = add (A + B); sampled with St.
- AccEn  input  1  1 = operand A is the current Result instead of the A port; sampled with St.
- A  input  WIDTH  minuend/augend; sampled with St.
- B  input  WIDTH  subtrahend/addend; sampled with St.
- Busy  output  1  high while the serial operation is in progress.
- Done  output  1  single-cycle completion pulse.
- Result  output  WIDTH  last completed result; held until the next completion.
- Z  output  1  Result == 0.
- N  output  1  Result[WIDTH-1].
- V  output  1  two's-complement overflow.
- C  output  1  carry-out (add) or borrow-out (subtract).

Behaviour:
- Reset (R=1, asynchronous):
  - State -> IDLE; bit counter, shift registers and carry/borrow FF cleared.
  - Busy=0, Done=0, Result=0, Z=0, N=0, V=0, C=0.
  - Reset mid-operation aborts the operation with no Done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Busy=0, Done=0.
  - Edge E0 with St=1: load operand registers (A source = AccEn ? Result : A), latch Mode, clear the carry/borrow FF, counter=0, go to SHIFT.
  - St=0: remain in IDLE.
- SHIFT:
  - Busy=1.
  - One bit per edge, LSB first, on edges E1..E_WIDTH.
  - Cell: sum/diff bit = a ^ b ^ cb.
  - Add: cb_next = a&b | a&cb | b&cb.
  - Sub: cb_next = ~a&b | ~a&cb | b&cb (borrow).
  - Result bit is shifted into the accumulator MSB; accumulator and operand registers shift right; counter increments.
  - St, Mode, AccEn, A, B are ignored while in SHIFT.
- Completion edge E_WIDTH:
  - Result <= assembled WIDTH-bit value.
  - C <= final cb.
  - Z, N <= derived from the new Result.
  - V, with a, b = operand MSBs and r = Result MSB:
    - Add: V = (a == b) & (r != a).
    - Sub: V = (a != b) & (r != a).
  - State -> DONE.
- DONE:
  - Busy=0, Done=1 for exactly one cycle.
  - St is ignored.
  - Next edge -> IDLE.
- Latency and throughput:
  - Done is high in the cycle beginning WIDTH edges after the St-sampling edge.
  - Busy is high for exactly WIDTH cycles.
  - Back-to-back starts: one operation per WIDTH+2 cycles.
- Result and all flags change only at a completion edge or on reset; they are stable at every other time.
- Arithmetic is modulo 2^WIDTH. Subtract C=1 iff A < B unsigned.
- AccEn=1 with Mode=1 and B=0 reproduces the previous Result; flags are recomputed and C=0.

Test Plan:
- Subtract, WIDTH=8, A=0x34, B=0xF7, Mode=0, St pulse -> after 8 cycles Done pulses; Result=0x3D, Z=0, N=0, V=0, C=1; Busy high for exactly 8 cycles.
- Add signed overflow: A=0x7F, B=0x01, Mode=1 -> Result=0x80, Z=0, N=1, V=1, C=0.
- Equal subtract: A=0x55, B=0x55, Mode=0 -> Result=0x00, Z=1, N=0, V=0, C=0. Then add A=0xFF, B=0x01 -> Result=0x00, Z=1, C=1, V=0.
- Accumulate: after Result=0x80, issue AccEn=1, A=0x12 (ignored), B=0x80, Mode=1 -> Result=0x00, Z=1, C=1, V=1.
- Handshake robustness:
  - St held high continuously -> new operation starts every 10 cycles; Done is one cycle wide each time.
  - Operand changes during SHIFT do not affect Result.
- Reset mid-operation: assert R asynchronously 3 cycles into SHIFT -> Busy, Done, Result and flags go to 0 immediately, with no Done pulse. After R deasserts, a new St with A=0x0A, B=0x03, Mode=0 gives Result=0x07.
- WIDTH=16 instance: A=0x8000, B=0x0001, Mode=0 -> Result=0x7FFF, V=1, N=0, C=0; Done after 16 cycles.
